// File: rtl/acc_drain.sv
// Requantizing drain stage: signed accumulator stream -> shift/saturate -> 3-deep skid FIFO.
// Define ACC_DRAIN_ROUND_EN for round-half-up before the shift; otherwise the shift truncates.
module acc_drain #(
  parameter int unsigned WY      = 16,
  parameter int unsigned WO      = 8,
  parameter int unsigned N_BEATS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WY-1:0]    s_data,
  input  logic [$clog2(WY)-1:0]   shift,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [WO-1:0]    m_data,
  output logic                    m_last,
  output logic                    sat_flag
);

  localparam int unsigned BW = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic signed [WY:0] QMAX = {{(WY-WO+2){1'b0}}, {(WO-1){1'b1}}};
  localparam logic signed [WY:0] QMIN = {{(WY-WO+2){1'b1}}, {(WO-1){1'b0}}};

  logic [WO-1:0] p_q;
  logic          p_v_q;
  logic [WO-1:0] mem_q [3];
  logic [1:0]    wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q;
  logic [BW-1:0] beat_q;
  logic          sat_q;

  logic signed [WY:0] ext, sum, shifted;
  logic [WO-1:0]      q;
  logic               q_sat;
  logic               accept, push, pop;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    ext = {s_data[WY-1], s_data};
`ifdef ACC_DRAIN_ROUND_EN
    sum = ext;
    if (shift != '0) begin
      sum = ext + ((WY+1)'(1) << (shift - 1'b1));
    end
`else
    sum = ext;
`endif
    shifted = sum >>> shift;
    q       = shifted[WO-1:0];
    q_sat   = 1'b0;
    if (shifted > QMAX) begin
      q     = QMAX[WO-1:0];
      q_sat = 1'b1;
    end else if (shifted < QMIN) begin
      q     = QMIN[WO-1:0];
      q_sat = 1'b1;
    end
  end

  // Ready depends only on registered occupancy, so the P->FIFO move can never stall.
  assign s_ready  = ({1'b0, count_q} + {2'b00, p_v_q}) <= 3'd2;
  assign m_valid  = (count_q != 2'd0);
  assign m_data   = m_valid ? mem_q[rd_ptr_q] : '0;
  assign m_last   = (beat_q == BW'(N_BEATS - 1));
  assign sat_flag = sat_q;

  assign accept = s_valid && s_ready;
  assign push   = p_v_q;
  assign pop    = m_valid && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q      <= '0;
      p_v_q    <= 1'b0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 2'd0;
      beat_q   <= '0;
      sat_q    <= 1'b0;
      for (int i = 0; i < 3; i++) mem_q[i] <= '0;
    end else begin
      p_v_q <= accept;
      if (accept) begin
        p_q <= q;
        if (q_sat) sat_q <= 1'b1;
      end
      if (push) begin
        mem_q[wr_ptr_q] <= p_q;
        wr_ptr_q        <= inc3(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= inc3(rd_ptr_q);
        beat_q   <= (beat_q == BW'(N_BEATS - 1)) ? '0 : beat_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_drain.sv
// Directed self-checking bench for acc_drain (WY=16, WO=8, N_BEATS=4).
module tb_acc_drain;

  logic              clk, rst;
  logic              s_valid, s_ready;
  logic signed [15:0] s_data;
  logic [3:0]        shift;
  logic              m_valid, m_ready, m_last, sat_flag;
  logic signed [7:0] m_data;

  int n_vec = 0;
  int n_err = 0;

  acc_drain #(.WY(16), .WO(8), .N_BEATS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .shift    (shift),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .sat_flag (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; shift = '0; m_ready = 1'b0;
    tick; tick;
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid got %b want 0", m_valid); end
    n_vec++; if (m_data !== 8'h00) begin n_err++; $display("FAIL rst_m_data got %h want 00", m_data); end
    n_vec++; if (m_last !== 1'b0) begin n_err++; $display("FAIL rst_m_last got %b want 0", m_last); end
    n_vec++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL rst_sat got %b want 0", sat_flag); end
    n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL rst_s_ready got %b want 1", s_ready); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_quant(input string name, input logic [15:0] d, input logic [3:0] sh,
                            input logic [7:0] exp_d, input logic exp_sat);
    m_ready = 1'b1; s_valid = 1'b1; s_data = d; shift = sh;
    n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL %s_ready got %b want 1", name, s_ready); end
    tick;
    s_valid = 1'b0;
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL %s_lat1 got %b want 0", name, m_valid); end
    tick;
    n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL %s_lat2 got %b want 1", name, m_valid); end
    n_vec++; if (m_data !== exp_d) begin n_err++; $display("FAIL %s_data got %h want %h", name, m_data, exp_d); end
    tick;
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL %s_pop got %b want 0", name, m_valid); end
    n_vec++; if (sat_flag !== exp_sat) begin n_err++; $display("FAIL %s_sat got %b want %b", name, sat_flag, exp_sat); end
  endtask

  task automatic test_backpressure;
    logic [7:0] got[$];
    int idx;
    bit acc;
    do_reset;
    m_ready = 1'b0; shift = 4'd4; idx = 0; s_valid = 1'b1; s_data = 16'd16;
    for (int c = 0; c < 8; c++) begin
      acc = s_valid && s_ready;
      tick;
      if (acc) begin
        idx++;
        if (idx < 5) s_data = 16'((idx + 1) * 16); else s_valid = 1'b0;
      end
    end
    n_vec++; if (idx !== 3) begin n_err++; $display("FAIL bp_accepted got %0d want 3", idx); end
    n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL bp_s_ready got %b want 0", s_ready); end
    n_vec++; if (m_valid !== 1'b1 || m_data !== 8'd1) begin
      n_err++; $display("FAIL bp_hold got v=%b d=%h want v=1 d=01", m_valid, m_data);
    end
    m_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (m_valid) got.push_back(m_data);
      acc = s_valid && s_ready;
      tick;
      if (acc) begin
        idx++;
        if (idx < 5) s_data = 16'((idx + 1) * 16); else s_valid = 1'b0;
      end
    end
    n_vec++; if (idx !== 5) begin n_err++; $display("FAIL bp_resume got %0d want 5", idx); end
    n_vec++; if (got.size() !== 5) begin n_err++; $display("FAIL bp_count got %0d want 5", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      n_vec++;
      if (got[i] !== 8'(i + 1)) begin
        n_err++; $display("FAIL bp_order[%0d] got %h want %h", i, got[i], 8'(i + 1));
      end
    end
  endtask

  task automatic test_packet;
    int idx, out, first_acc, last_acc, first_v, last_v;
    bit acc;
    do_reset;
    m_ready = 1'b1; shift = 4'd5; idx = 0; s_valid = 1'b1; s_data = 16'd32;
    out = 0; first_acc = -1; last_acc = -1; first_v = -1; last_v = -1;
    for (int c = 0; c < 30; c++) begin
      if (m_valid) begin
        if (first_v < 0) first_v = c;
        last_v = c;
        n_vec++;
        if (m_last !== ((out % 4) == 3)) begin
          n_err++; $display("FAIL pkt_last[%0d] got %b want %b", out, m_last, (out % 4) == 3);
        end
        n_vec++;
        if (m_data !== 8'(out + 1)) begin
          n_err++; $display("FAIL pkt_data[%0d] got %h want %h", out, m_data, 8'(out + 1));
        end
        out++;
      end
      acc = s_valid && s_ready;
      tick;
      if (acc) begin
        if (first_acc < 0) first_acc = c;
        last_acc = c;
        idx++;
        if (idx < 8) s_data = 16'((idx + 1) * 32); else s_valid = 1'b0;
      end
    end
    n_vec++; if (out !== 8) begin n_err++; $display("FAIL pkt_count got %0d want 8", out); end
    n_vec++; if (first_v - first_acc !== 2) begin
      n_err++; $display("FAIL pkt_latency got %0d want 2", first_v - first_acc);
    end
    n_vec++; if (last_acc - first_acc !== 7 || last_v - first_v !== 7) begin
      n_err++; $display("FAIL pkt_rate got in=%0d out=%0d want 7", last_acc - first_acc, last_v - first_v);
    end
  endtask

  task automatic drive_beat(input logic [15:0] d, input logic [3:0] sh);
    bit acc;
    s_valid = 1'b1; s_data = d; shift = sh;
    acc = 1'b0;
    for (int c = 0; c < 20 && !acc; c++) begin
      acc = s_ready;
      tick;
    end
    s_valid = 1'b0;
    n_vec++; if (!acc) begin n_err++; $display("FAIL drive_timeout got 0 want 1"); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive_beat(16'd16, 4'd4);
    tick; tick; tick;
    n_vec++; if (m_last !== 1'b1) begin n_err++; $display("FAIL mid_pre_last got %b want 1", m_last); end
    m_ready = 1'b0;
    drive_beat(16'h7FFF, 4'd0);
    drive_beat(16'd32, 4'd4);
    tick;
    n_vec++; if (m_valid !== 1'b1 || sat_flag !== 1'b1) begin
      n_err++; $display("FAIL mid_pre got v=%b sat=%b want 1 1", m_valid, sat_flag);
    end
    rst = 1'b1;
    #1;
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL mid_m_valid got %b want 0", m_valid); end
    n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL mid_s_ready got %b want 1", s_ready); end
    n_vec++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL mid_sat got %b want 0", sat_flag); end
    n_vec++; if (m_last !== 1'b0) begin n_err++; $display("FAIL mid_m_last got %b want 0", m_last); end
    tick;
    rst = 1'b0;
    m_ready = 1'b1;
    drive_beat(16'd48, 4'd4);
    tick;
    n_vec++; if (m_valid !== 1'b1 || m_data !== 8'd3) begin
      n_err++; $display("FAIL mid_post got v=%b d=%h want v=1 d=03", m_valid, m_data);
    end
    n_vec++; if (m_last !== 1'b0) begin n_err++; $display("FAIL mid_post_last got %b want 0", m_last); end
    tick;
  endtask

  initial begin
    test_reset;
`ifdef ACC_DRAIN_ROUND_EN
    test_quant("q344",   16'h0158, 4'd4,  8'd22,  1'b0);
    test_quant("qm24",   16'hFFE8, 4'd4,  8'hFF,  1'b0);
    test_quant("qmaxs15", 16'h7FFF, 4'd15, 8'h01, 1'b0);
`else
    test_quant("q344",   16'h0158, 4'd4,  8'd21,  1'b0);
    test_quant("qm24",   16'hFFE8, 4'd4,  8'hFE,  1'b0);
    test_quant("qmaxs15", 16'h7FFF, 4'd15, 8'h00, 1'b0);
`endif
    test_quant("qmins15", 16'h8000, 4'd15, 8'hFF, 1'b0);
    test_quant("qsatp",  16'h7FFF, 4'd0,  8'h7F,  1'b1);
    test_quant("qsatn",  16'h8000, 4'd0,  8'h80,  1'b1);
    test_quant("qstick", 16'h0010, 4'd4,  8'h01,  1'b1);
    test_backpressure;
    test_packet;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/acc_drain.md
ACC_DRAIN -- requirements
Module: acc_drain

Interface
REQ-001 The block SHALL have parameter WY, default 16, meaning accumulator input width in bits.
REQ-002 The block SHALL have parameter WO, default 8, meaning requantized output width in bits, with WO < WY.
REQ-003 The block SHALL have parameter N_BEATS, default 4, meaning output beats per packet (m_last period), N_BEATS >= 1.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-005 The block SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-006 The block SHALL have ports s_valid input 1, s_ready output 1, s_data input WY (signed), meaning accumulator result stream in.
REQ-007 The block SHALL have port shift, input, $clog2(WY), meaning right-shift amount, sampled with each accepted beat.
REQ-008 The block SHALL have ports m_valid output 1, m_ready input 1, m_data output WO (signed), m_last output 1, meaning the requantized stream out.
REQ-009 The block SHALL have port sat_flag, output, 1, meaning sticky saturation indicator.

Function
REQ-010 The block SHALL accept an input beat iff s_valid && s_ready at a rising edge.
REQ-011 The block SHALL have a compute register P with valid bit p_v, and a 3-entry in-order output FIFO with occupancy count.
REQ-012 The block SHALL drive s_ready = (count + p_v) <= 2, from registered state only, with no combinational path from m_ready.
REQ-013 The block SHALL, on acceptance, load P with the requantized value of s_data under that cycle's shift.
REQ-014 Requantization SHALL use WY+1-bit signed arithmetic: optional rounding add (REQ-024), arithmetic shift right by shift, saturate to [-2^(WO-1), 2^(WO-1)-1].
REQ-015 The block SHALL move P into the FIFO on the next edge whenever p_v=1; the move SHALL never stall, guaranteed by REQ-012.
REQ-016 The block SHALL drive m_valid = (count > 0) and m_data = FIFO head; the head SHALL pop when m_valid && m_ready.
REQ-017 Latency SHALL be 2 cycles: a beat accepted at edge k shows m_valid=1 after edge k+2, when the FIFO was empty.
REQ-018 Throughput SHALL be 1 beat/cycle with m_ready held high.
REQ-019 A simultaneous FIFO push and pop SHALL leave count unchanged and preserve order.
REQ-020 m_valid/m_data/m_last SHALL stay stable while m_valid && !m_ready.
REQ-021 An output beat counter SHALL advance on each pop, wrapping from N_BEATS-1 to 0; m_last SHALL be 1 iff the counter equals N_BEATS-1.
REQ-022 sat_flag SHALL set when any accepted beat saturates, and SHALL clear only on reset.

Reset
REQ-023 While rst=1 the block SHALL clear p_v, count, FIFO pointers, beat counter and sat_flag; outputs read m_valid=0, m_data=0, m_last=0 (N_BEATS>1), sat_flag=0, s_ready=1; in-flight data SHALL be discarded, including reset mid-packet.

Configuration
REQ-024 Macro ACC_DRAIN_ROUND_EN defined: the block SHALL add 2^(shift-1) before shifting when shift>0 (round-half-up); undefined: it SHALL truncate (floor), with no rounding adder.

Verification
REQ-025 WY=16, WO=8: s_data=344 (0x0158), shift=4 -> m_data=22 with ROUND_EN, 21 without; sat_flag=0.
REQ-026 s_data=-24 (0xFFE8), shift=4 -> m_data=-1 (0xFF) with ROUND_EN, -2 (0xFE) without.
REQ-027 s_data=0x7FFF, shift=0 -> m_data=127 (0x7F), sat_flag=1 and stays 1; s_data=0x8000, shift=0 -> m_data=-128 (0x80).
REQ-028 m_ready=0, s_valid held high with 5 beats -> exactly 3 accepted, then s_ready=0; after m_ready=1 the 3 beats appear in order and input resumes.
REQ-029 N_BEATS=4, 8 beats, m_ready=1 -> m_last=1 on output beats 4 and 8 only; first output 2 cycles after first acceptance.
REQ-030 Assert rst with 2 beats in flight -> m_valid=0 immediately, s_ready=1, sat_flag=0; post-reset beat gets m_last per a fresh count.
